// File: rtl/event_blinker.sv
// One fixed-length blink per rising edge of event_in, with a guaranteed dark gap
// and a saturating queue of pending blinks. Define EVENT_BLINKER_OVERFLOW_EN to add a sticky overflow flag.
module event_blinker #(
    parameter int unsigned ON_CYCLES   = 12500000,
    parameter int unsigned OFF_CYCLES  = 12500000,
    parameter int unsigned MAX_PENDING = 7
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               event_in,
    output logic                               out,
    output logic                               busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending
`ifdef EVENT_BLINKER_OVERFLOW_EN
    ,
    output logic                               overflow
`endif
);

    localparam int unsigned MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned PW   = $clog2(MAX_PENDING + 1);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          prev;
    logic          rise;
    logic          pend_full;

    always_comb begin
        rise      = event_in & ~prev;
        pend_full = (pending == PEND_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            prev    <= 1'b0;
            out     <= 1'b0;
            busy    <= 1'b0;
            pending <= '0;
`ifdef EVENT_BLINKER_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else begin
            prev <= event_in;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= ON;
                        count <= ON_LOAD;
                        out   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ON, GAP: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else if (state == ON) begin
                        state <= GAP;
                        count <= OFF_LOAD;
                        out   <= 1'b0;
                    end else if (pending != '0 || rise) begin
                        state <= ON;
                        count <= ON_LOAD;
                        out   <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end

                    // Last GAP cycle: a new edge either replaces the dequeued blink or starts directly.
                    if (state == GAP && count == '0) begin
                        if (pending != '0 && !rise)
                            pending <= pending - 1'b1;
                    end else if (rise) begin
                        if (!pend_full)
                            pending <= pending + 1'b1;
`ifdef EVENT_BLINKER_OVERFLOW_EN
                        else
                            overflow <= 1'b1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_blinker.sv
// Directed bench for event_blinker with ON_CYCLES=3, OFF_CYCLES=2, MAX_PENDING=2.
module tb_event_blinker;

    logic       clk;
    logic       reset;
    logic       event_in;
    logic       out;
    logic       busy;
    logic [1:0] pending;
`ifdef EVENT_BLINKER_OVERFLOW_EN
    logic       overflow;
`endif

    int vectors;
    int miscompares;

    event_blinker #(
        .ON_CYCLES  (3),
        .OFF_CYCLES (2),
        .MAX_PENDING(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .event_in(event_in),
        .out     (out),
        .busy    (busy),
        .pending (pending)
`ifdef EVENT_BLINKER_OVERFLOW_EN
        ,
        .overflow(overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive event_in for the next posedge, then check outputs on the following negedge.
    task automatic step(input string tag, input logic ev, input int o, input int b, input int p);
        event_in = ev;
        @(negedge clk);
        check({tag, ".out"},     int'(out),     o);
        check({tag, ".busy"},    int'(busy),    b);
        check({tag, ".pending"}, int'(pending), p);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        event_in    = 1'b1;

        // 1: event_in high through reset release counts as one edge
        step("t1_rst", 1'b1, 0, 0, 0);
        step("t1_rst", 1'b1, 0, 0, 0);
`ifdef EVENT_BLINKER_OVERFLOW_EN
        check("t1_rst.overflow", int'(overflow), 0);
`endif
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step("t1_on", 1'b1, 1, 1, 0);
        for (int i = 0; i < 2; i++) step("t1_gap", 1'b1, 0, 1, 0);
        step("t1_idle", 1'b1, 0, 0, 0);
        step("t1_idle", 1'b0, 0, 0, 0);

        // 2: single pulse
        step("t2_on", 1'b1, 1, 1, 0);
        step("t2_on", 1'b0, 1, 1, 0);
        step("t2_on", 1'b0, 1, 1, 0);
        for (int i = 0; i < 2; i++) step("t2_gap", 1'b0, 0, 1, 0);
        step("t2_idle", 1'b0, 0, 0, 0);

        // 3: level held 10 cycles gives one blink
        for (int i = 0; i < 3; i++) step("t3_on", 1'b1, 1, 1, 0);
        for (int i = 0; i < 2; i++) step("t3_gap", 1'b1, 0, 1, 0);
        for (int i = 0; i < 5; i++) step("t3_idle", 1'b1, 0, 0, 0);
        step("t3_idle", 1'b0, 0, 0, 0);

        // 4: queueing and saturation (4 blinks, one edge dropped)
        step("t4_a", 1'b1, 1, 1, 0);
        step("t4_b", 1'b0, 1, 1, 0);
        step("t4_c", 1'b1, 1, 1, 1);
        step("t4_d", 1'b0, 0, 1, 1);
        step("t4_e", 1'b1, 0, 1, 2);
        step("t4_f", 1'b0, 1, 1, 1);
        step("t4_g", 1'b1, 1, 1, 2);
        step("t4_h", 1'b0, 1, 1, 2);
`ifdef EVENT_BLINKER_OVERFLOW_EN
        check("t4_h.overflow", int'(overflow), 0);
`endif
        step("t4_i", 1'b1, 0, 1, 2);
`ifdef EVENT_BLINKER_OVERFLOW_EN
        check("t4_i.overflow", int'(overflow), 1);
`endif
        step("t4_j", 1'b0, 0, 1, 2);
        for (int i = 0; i < 3; i++) step("t4_on3", 1'b0, 1, 1, 1);
        for (int i = 0; i < 2; i++) step("t4_gap3", 1'b0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step("t4_on4", 1'b0, 1, 1, 0);
        for (int i = 0; i < 2; i++) step("t4_gap4", 1'b0, 0, 1, 0);
        step("t4_idle", 1'b0, 0, 0, 0);

        // 5: edge on last GAP cycle with nothing queued chains directly
        step("t5_on", 1'b1, 1, 1, 0);
        step("t5_on", 1'b0, 1, 1, 0);
        step("t5_on", 1'b0, 1, 1, 0);
        step("t5_gap", 1'b0, 0, 1, 0);
        step("t5_gap", 1'b0, 0, 1, 0);
        step("t5_chain", 1'b1, 1, 1, 0);
        step("t5_on2", 1'b0, 1, 1, 0);
        step("t5_on2", 1'b0, 1, 1, 0);
        step("t5_gap2", 1'b0, 0, 1, 0);
        step("t5_gap2", 1'b0, 0, 1, 0);
        step("t5_idle", 1'b0, 0, 0, 0);

        // 6: reset in second ON cycle of a blink with one queued
        step("t6_a", 1'b1, 1, 1, 0);
        step("t6_b", 1'b0, 1, 1, 0);
        step("t6_c", 1'b1, 1, 1, 1);
        step("t6_d", 1'b0, 0, 1, 1);
        step("t6_e", 1'b0, 0, 1, 1);
        step("t6_f", 1'b0, 1, 1, 0);
        step("t6_g", 1'b1, 1, 1, 1);
        reset = 1'b1;
        step("t6_rst", 1'b0, 0, 0, 0);
`ifdef EVENT_BLINKER_OVERFLOW_EN
        check("t6_rst.overflow", int'(overflow), 0);
`endif
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step("t6_after", 1'b0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
